// File: rtl/acc_mul_seq.sv
// Shift-and-add sequencer for an unsigned WIDTHxWIDTH multiply (low WIDTH bits kept),
// built around an external falling-edge accumulator whose clear, enable and data-in it owns.
module acc_mul_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc_q,
   output logic [WIDTH-1:0] acc_d,
   output logic             acc_wr_en,
   output logic             acc_rst,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      STEP   = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_result;
   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   always_comb begin
      w_last = (r_cnt == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = CLEAR;
         CLEAR:   w_next = STEP;
         STEP:    if (w_last) w_next = FINISH;
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // acc_q already holds the final partial sum here: the accumulator took the last
   // add on the falling edge inside this STEP cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= a;
                  r_mplier <= b;
                  r_cnt    <= '0;
               end
            end
            STEP: begin
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (w_last) r_result <= acc_q;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = (r_state != IDLE);
      done      = (r_state == FINISH);
      acc_rst   = rst | (r_state == CLEAR);
      acc_wr_en = (r_state == STEP) & r_mplier[0];
      acc_d     = '0;
      if (r_state == STEP) acc_d = acc_q + r_mcand;
      result    = r_result;
   end

endmodule

// File: tb/tb_acc_mul_seq.sv
// Bench for acc_mul_seq with a behavioural falling-edge accumulator and a result scoreboard.
module tb_acc_mul_seq;
   localparam int WIDTH = 16;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic             acc_wr_en;
   logic             acc_rst;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   int               checks = 0;
   int               errors = 0;
   int               wr_count = 0;
   logic [WIDTH-1:0] exp_q[$];

   acc_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .acc_q(acc_q), .acc_d(acc_d), .acc_wr_en(acc_wr_en), .acc_rst(acc_rst),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   // acc_16b: samples on the falling edge
   always @(negedge clk) begin
      if (acc_rst) acc_q <= '0;
      else if (acc_wr_en) acc_q <= acc_d;
   end

   always @(negedge clk) if (acc_wr_en) wr_count++;

   function automatic logic [WIDTH-1:0] prod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [2*WIDTH-1:0] p;
      p = x * y;
      return p[WIDTH-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive a start in IDLE; returns one edge after acceptance
   task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      a = x; b = y; start = 1'b1;
      exp_q.push_back(prod(x, y));
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output logic [WIDTH-1:0] res, output bit ok);
      lat = 0; ok = 1'b0; res = '0;
      for (int i = 0; i < 40; i++) begin
         tick();
         lat++;
         if (done) begin
            ok = 1'b1;
            res = result;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
      checks++; if (acc_rst !== 1'b1) begin errors++; $display("FAIL reset_acc_rst got %b exp 1", acc_rst); end
      checks++; if (acc_q !== '0) begin errors++; $display("FAIL reset_acc_q got %h exp 0", acc_q); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (acc_rst !== 1'b0 || acc_wr_en !== 1'b0) begin errors++; $display("FAIL idle_ctrl got rst=%b wr=%b exp 0 0", acc_rst, acc_wr_en); end
   endtask

   task automatic test_basic();
      int lat; logic [WIDTH-1:0] res; bit ok; logic [WIDTH-1:0] e;
      issue(16'd3, 16'd5);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
      checks++; if (acc_rst !== 1'b1) begin errors++; $display("FAIL basic_clear got %b exp 1", acc_rst); end
      a = 16'hDEAD; b = 16'hBEEF;
      wait_done(lat, res, ok);
      e = exp_q.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no done exp done"); end
      checks++; if (lat != 17) begin errors++; $display("FAIL basic_latency got %0d exp 17", lat); end
      checks++; if (res !== e) begin errors++; $display("FAIL basic_result got %h exp %h", res, e); end
      checks++; if (acc_q !== 16'd15) begin errors++; $display("FAIL basic_acc_q got %h exp 000f", acc_q); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_end got done=%b busy=%b exp 0 0", done, busy); end
      checks++; if (result !== 16'd15) begin errors++; $display("FAIL basic_hold got %h exp 000f", result); end
   endtask

   task automatic test_wrap();
      logic [WIDTH-1:0] ta[3];
      logic [WIDTH-1:0] tb_[3];
      int lat; logic [WIDTH-1:0] res; bit ok; logic [WIDTH-1:0] e;
      ta[0] = 16'hFFFF; tb_[0] = 16'hFFFF;
      ta[1] = 16'h0100; tb_[1] = 16'h0100;
      ta[2] = 16'h1234; tb_[2] = 16'h0000;
      for (int k = 0; k < 3; k++) begin
         wr_count = 0;
         issue(ta[k], tb_[k]);
         wait_done(lat, res, ok);
         e = exp_q.pop_front();
         checks++; if (!ok || res !== e) begin errors++; $display("FAIL wrap_%0d got %h ok=%0d exp %h", k, res, ok, e); end
         if (k == 2) begin
            checks++; if (wr_count != 0) begin errors++; $display("FAIL zero_mplier_wr got %0d exp 0", wr_count); end
         end
         tick();
      end
   endtask

   task automatic test_ignore_start();
      int lat; logic [WIDTH-1:0] res; bit ok; logic [WIDTH-1:0] e;
      issue(16'd7, 16'd6);
      a = 16'd9; b = 16'd9; start = 1'b1;
      wait_done(lat, res, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || res !== e) begin errors++; $display("FAIL ignore_result got %h exp %h", res, e); end
      checks++; if (lat != 17) begin errors++; $display("FAIL ignore_latency got %0d exp 17", lat); end
      tick();
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignore_idle got busy=%b done=%b exp 0 0", busy, done); end
      exp_q.push_back(prod(16'd9, 16'd9));
      tick();
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_accept got %b exp 1", busy); end
      wait_done(lat, res, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || res !== e) begin errors++; $display("FAIL ignore_second got %h exp %h", res, e); end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat; logic [WIDTH-1:0] res; bit ok; logic [WIDTH-1:0] e;
      a = 16'd100; b = 16'd100; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b done=%b exp 0 0", busy, done); end
      checks++; if (result !== '0) begin errors++; $display("FAIL midrst_result got %h exp 0", result); end
      checks++; if (acc_q === '0) begin errors++; $display("FAIL midrst_pre_acc got %h exp nonzero", acc_q); end
      @(negedge clk); #1;
      checks++; if (acc_q !== '0) begin errors++; $display("FAIL midrst_acc_q got %h exp 0", acc_q); end
      tick();
      rst = 1'b0;
      issue(16'd2, 16'd3);
      wait_done(lat, res, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || res !== e) begin errors++; $display("FAIL midrst_restart got %h exp %h", res, e); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] va[4];
      logic [WIDTH-1:0] vb[4];
      int lat; logic [WIDTH-1:0] res; bit ok; logic [WIDTH-1:0] e;
      va[0] = 16'd11;   vb[0] = 16'd13;
      va[1] = 16'h00FF; vb[1] = 16'h0101;
      va[2] = 16'hABCD; vb[2] = 16'h0003;
      va[3] = 16'd1;    vb[3] = 16'd1;
      a = va[0]; b = vb[0]; start = 1'b1;
      exp_q.push_back(prod(va[0], vb[0]));
      tick();
      for (int k = 0; k < 3; k++) begin
         a = va[k+1]; b = vb[k+1];
         wait_done(lat, res, ok);
         e = exp_q.pop_front();
         checks++; if (!ok || res !== e) begin errors++; $display("FAIL b2b_%0d got %h exp %h", k, res, e); end
         tick();
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_%0d got %b exp 0", k, busy); end
         if (k < 2) exp_q.push_back(prod(va[k+1], vb[k+1]));
         else start = 1'b0;
         tick();
         if (k < 2) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_%0d got %b exp 1", k, busy); end
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
